// File: rtl/unary_add_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | unary_add_pkg : shared types and helpers for the N-channel unary adder|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package unary_add_pkg;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int sum_width(input int nch, input int maxlen);
      return $clog2(nch * maxlen + 1);
   endfunction

   // Adds with one spare carry bit so the clip never sees a wrapped value.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] limit);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, limit}) ? limit : s[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/unary_popcount.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | unary_popcount : combinational count of set bits across all channels  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module unary_popcount #(
   parameter  int NCH = 2,
   localparam int PW  = $clog2(NCH + 1)
) (
   input  logic [NCH-1:0] din,
   output logic [PW-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < NCH; i++) begin
         count = count + PW'(din[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/unary_add_nch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | unary_add_nch : N-channel saturating unary adder with unary re-emission|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module unary_add_nch
   import unary_add_pkg::*;
#(
   parameter  int NCH     = 2,
   parameter  int MAXLEN  = 15,
   parameter  int OUT_MAX = 30,
   localparam int SW      = sum_width(NCH, MAXLEN)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           read_or_write,
   input  logic [NCH-1:0] din,
   output logic           dout,
   output logic           C,
   output logic [SW-1:0]  sum_o,
   output logic           done
);

   localparam int          PW        = $clog2(NCH + 1);
   localparam logic [31:0] ACC_MAX   = 32'((64'd1 << SW) - 64'd1);
   localparam logic [SW-1:0] OUT_MAX_W = SW'(OUT_MAX);

   state_t        state, state_n;
   logic [SW-1:0] acc, acc_n;
   logic [SW-1:0] rem, rem_n;
   logic          dout_n, c_n, done_n;
   logic [PW-1:0] pop;
   logic [SW-1:0] base;
   logic [SW-1:0] acc_sat;
   logic [SW-1:0] load;

   unary_popcount #(.NCH(NCH)) u_popcount (
      .din   (din),
      .count (pop)
   );

   // Leaving EMIT/DONE for a new frame starts from an empty sum.
   assign base    = (state == ACC) ? acc : '0;
   assign acc_sat = SW'(sat_add(32'(base), 32'(pop), ACC_MAX));
   assign load    = (acc > OUT_MAX_W) ? OUT_MAX_W : acc;
   assign sum_o   = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACC;
         acc   <= '0;
         rem   <= '0;
         dout  <= 1'b0;
         C     <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         rem   <= rem_n;
         dout  <= dout_n;
         C     <= c_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      rem_n   = rem;
      dout_n  = dout;
      c_n     = C;
      done_n  = 1'b0;
      if (en) begin
         if (!read_or_write) begin
            state_n = ACC;
            acc_n   = acc_sat;
            c_n     = (acc_sat > OUT_MAX_W);
            rem_n   = '0;
            dout_n  = 1'b0;
         end else begin
            case (state)
               ACC: begin
                  if (load == '0) begin
                     state_n = DONE;
                     done_n  = 1'b1;
                     dout_n  = 1'b0;
                  end else begin
                     state_n = EMIT;
                     rem_n   = load;
                     dout_n  = 1'b1;
                  end
               end
               // rem counts the 1s still to show, including the one on dout now.
               EMIT: begin
                  if (rem == SW'(1)) begin
                     state_n = DONE;
                     rem_n   = '0;
                     dout_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     rem_n  = rem - SW'(1);
                     dout_n = 1'b1;
                  end
               end
               DONE: begin
                  dout_n = 1'b0;
               end
               default: begin
                  state_n = ACC;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unary_add_nch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_unary_add_nch : directed self-checking bench for unary_add_nch     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_unary_add_nch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, rw;
   logic [1:0] din;
   logic       dout, c, done;
   logic [4:0] sum_o;

   logic       en2, rw2;
   logic [3:0] din2;
   logic       dout2, c2, done2;
   logic [5:0] sum2;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   unary_add_nch dut (
      .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din),
      .dout(dout), .C(c), .sum_o(sum_o), .done(done)
   );

   unary_add_nch #(.NCH(4), .MAXLEN(15), .OUT_MAX(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en2), .read_or_write(rw2), .din(din2),
      .dout(dout2), .C(c2), .sum_o(sum2), .done(done2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts dout-high cycles following en=1 edges and done pulses on the default instance.
   task automatic run_emit(input int cycles, output int first, output int highs,
                           output int dones, output int bad_done);
      highs = 0; dones = 0; bad_done = 0; first = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (i == 0) first = int'(dout);
         if (dout) highs++;
         if (done) begin
            dones++;
            if (dout) bad_done++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; rw = 1'b0; din = '0;
      en2 = 1'b0; rw2 = 1'b0; din2 = '0;
      step(); step();
      total++;
      if ({dout, c, done, sum_o} !== 8'd0) $display("FAIL reset_outputs: got %b, want 0", {dout, c, done, sum_o});
      else pass_cnt++;
      total++;
      if ({dout2, c2, done2, sum2} !== 9'd0) $display("FAIL reset_outputs4: got %b, want 0", {dout2, c2, done2, sum2});
      else pass_cnt++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int first, highs, dones, bad;
      en = 1'b1; rw = 1'b0; din = 2'b11;
      for (int i = 0; i < 11; i++) step();
      total++;
      if (sum_o !== 5'd22) $display("FAIL basic_sum22: got %0d, want 22", sum_o);
      else pass_cnt++;
      din = 2'b01;
      step();
      total++;
      if (sum_o !== 5'd23 || c !== 1'b0) $display("FAIL basic_sum23: got sum %0d C %b, want 23 0", sum_o, c);
      else pass_cnt++;
      rw = 1'b1; din = 2'b00;
      run_emit(30, first, highs, dones, bad);
      total++;
      if (first !== 1) $display("FAIL basic_latency: got dout %0d, want 1", first);
      else pass_cnt++;
      total++;
      if (highs !== 23) $display("FAIL basic_highs: got %0d, want 23", highs);
      else pass_cnt++;
      total++;
      if (dones !== 1 || bad !== 0) $display("FAIL basic_done: got %0d pulses (%0d with dout), want 1 (0)", dones, bad);
      else pass_cnt++;
      total++;
      if (sum_o !== 5'd23) $display("FAIL basic_sum_hold: got %0d, want 23", sum_o);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back_saturate();
      int first, highs, dones, bad;
      rw = 1'b0; din = 2'b11;
      step();
      total++;
      if (sum_o !== 5'd2 || dout !== 1'b0 || done !== 1'b0)
         $display("FAIL b2b_clear: got sum %0d dout %b done %b, want 2 0 0", sum_o, dout, done);
      else pass_cnt++;
      for (int i = 0; i < 14; i++) step();
      total++;
      if (sum_o !== 5'd30 || c !== 1'b0) $display("FAIL sat_at_limit: got sum %0d C %b, want 30 0", sum_o, c);
      else pass_cnt++;
      step();
      total++;
      if (sum_o !== 5'd31 || c !== 1'b1) $display("FAIL sat_clip: got sum %0d C %b, want 31 1", sum_o, c);
      else pass_cnt++;
      rw = 1'b1; din = 2'b00;
      run_emit(40, first, highs, dones, bad);
      total++;
      if (highs !== 30 || dones !== 1) $display("FAIL sat_emit: got highs %0d dones %0d, want 30 1", highs, dones);
      else pass_cnt++;
      total++;
      if (c !== 1'b1) $display("FAIL sat_c_hold: got %b, want 1", c);
      else pass_cnt++;
   endtask

   task automatic test_zero();
      int first, highs, dones, bad;
      rw = 1'b0; din = 2'b00;
      step(); step();
      total++;
      if (sum_o !== 5'd0 || c !== 1'b0) $display("FAIL zero_sum: got sum %0d C %b, want 0 0", sum_o, c);
      else pass_cnt++;
      rw = 1'b1;
      step();
      total++;
      if (done !== 1'b1 || dout !== 1'b0) $display("FAIL zero_done: got done %b dout %b, want 1 0", done, dout);
      else pass_cnt++;
      run_emit(5, first, highs, dones, bad);
      total++;
      if (highs !== 0 || dones !== 0) $display("FAIL zero_quiet: got highs %0d dones %0d, want 0 0", highs, dones);
      else pass_cnt++;
   endtask

   task automatic test_pause();
      int first, highs, dones, bad, pre;
      bit held;
      rw = 1'b0; din = 2'b11;
      for (int i = 0; i < 5; i++) step();
      total++;
      if (sum_o !== 5'd10) $display("FAIL pause_sum: got %0d, want 10", sum_o);
      else pass_cnt++;
      rw = 1'b1; din = 2'b00; pre = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dout) pre++;
      end
      en = 1'b0; din = 2'b11; held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (dout !== 1'b1 || done !== 1'b0 || sum_o !== 5'd10) held = 1'b0;
      end
      total++;
      if (held !== 1'b1) $display("FAIL pause_hold: got dout %b done %b sum %0d, want 1 0 10", dout, done, sum_o);
      else pass_cnt++;
      en = 1'b1; din = 2'b00;
      run_emit(15, first, highs, dones, bad);
      total++;
      if (pre + highs !== 10 || dones !== 1) $display("FAIL pause_total: got highs %0d dones %0d, want 10 1", pre + highs, dones);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int first, highs, dones, bad;
      rw = 1'b0; din = 2'b11;
      for (int i = 0; i < 16; i++) step();
      rw = 1'b1; din = 2'b00;
      step(); step(); step();
      total++;
      if (dout !== 1'b1 || c !== 1'b1) $display("FAIL rst_pre: got dout %b C %b, want 1 1", dout, c);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({dout, c, done, sum_o} !== 8'd0) $display("FAIL rst_async: got %b, want 0", {dout, c, done, sum_o});
      else pass_cnt++;
      rw = 1'b0;
      step(); step();
      rst_n = 1'b1;
      din = 2'b01;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (sum_o !== 5'd3 || c !== 1'b0) $display("FAIL rst_new_sum: got sum %0d C %b, want 3 0", sum_o, c);
      else pass_cnt++;
      rw = 1'b1; din = 2'b00;
      run_emit(10, first, highs, dones, bad);
      total++;
      if (highs !== 3 || dones !== 1) $display("FAIL rst_new_emit: got highs %0d dones %0d, want 3 1", highs, dones);
      else pass_cnt++;
   endtask

   task automatic test_nch4_abort();
      int highs, dones;
      bit quiet;
      en2 = 1'b1; rw2 = 1'b0; din2 = 4'b1011;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (sum2 !== 6'd9 || c2 !== 1'b1) $display("FAIL nch4_sum: got sum %0d C %b, want 9 1", sum2, c2);
      else pass_cnt++;
      rw2 = 1'b1; din2 = 4'b0000; highs = 0; dones = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (dout2) highs++;
         if (done2) dones++;
      end
      total++;
      if (highs !== 8 || dones !== 1) $display("FAIL nch4_emit: got highs %0d dones %0d, want 8 1", highs, dones);
      else pass_cnt++;
      rw2 = 1'b0; din2 = 4'b1011;
      step();
      total++;
      if (sum2 !== 6'd3) $display("FAIL nch4_b2b: got %0d, want 3", sum2);
      else pass_cnt++;
      step(); step();
      rw2 = 1'b1; din2 = 4'b0000; quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (dout2 !== 1'b1 || done2 !== 1'b0) quiet = 1'b0;
      end
      rw2 = 1'b0;
      step();
      total++;
      if (sum2 !== 6'd0 || c2 !== 1'b0 || dout2 !== 1'b0 || done2 !== 1'b0)
         $display("FAIL nch4_abort: got sum %0d C %b dout %b done %b, want 0 0 0 0", sum2, c2, dout2, done2);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done2 !== 1'b0 || dout2 !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) $display("FAIL nch4_no_done: got %b, want 1", quiet);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back_saturate();
      test_zero();
      test_pause();
      test_reset_mid();
      test_nch4_abort();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
